// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, types and byte-access helpers for the PCA9685-style
// register bank driving the 16-channel pwm_driver.
//   - register address constants and bit positions
//   - led_regs_t: one channel's ON/OFF counts and full-on/full-off flags
//   - tb_state_e: timebase RUN/SLEEP state
//   - led_wr_byte / led_rd_byte: map a byte lane (ON_L, ON_H, OFF_L, OFF_H)
//     onto a led_regs_t
package pwm_pkg;

  localparam int unsigned NUM_CH = 16;

  localparam logic [7:0] ADDR_MODE1        = 8'h00;
  localparam logic [7:0] ADDR_LED0_ON_L    = 8'h06;
  localparam logic [7:0] ADDR_ALL_LED_ON_L = 8'hFA;
  localparam logic [7:0] ADDR_PRE_SCALE    = 8'hFE;

  localparam int unsigned SLEEP_BIT    = 4;
  localparam int unsigned FULL_ON_BIT  = 4;
  localparam int unsigned FULL_OFF_BIT = 4;

  typedef struct packed {
    logic [11:0] on;
    logic [11:0] off;
    logic        full_on;
    logic        full_off;
  } led_regs_t;

  localparam led_regs_t LED_RST = '{on: 12'h000, off: 12'h000, full_on: 1'b0, full_off: 1'b1};

  typedef enum logic {
    TB_RUN   = 1'b0,
    TB_SLEEP = 1'b1
  } tb_state_e;

  // sel: 0 = ON_L, 1 = ON_H, 2 = OFF_L, 3 = OFF_H
  function automatic led_regs_t led_wr_byte(input led_regs_t r, input logic [1:0] sel,
                                            input logic [7:0] d);
    led_regs_t n;
    n = r;
    case (sel)
      2'd0: n.on[7:0] = d;
      2'd1: begin
        n.on[11:8] = d[3:0];
        n.full_on  = d[FULL_ON_BIT];
      end
      2'd2: n.off[7:0] = d;
      default: begin
        n.off[11:8] = d[3:0];
        n.full_off  = d[FULL_OFF_BIT];
      end
    endcase
    return n;
  endfunction

  // High bytes read back with bits[7:5] as zero.
  function automatic logic [7:0] led_rd_byte(input led_regs_t r, input logic [1:0] sel);
    logic [7:0] v;
    case (sel)
      2'd0:    v = r.on[7:0];
      2'd1:    v = {3'b000, r.full_on, r.on[11:8]};
      2'd2:    v = r.off[7:0];
      default: v = {3'b000, r.full_off, r.off[11:8]};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pwm_sequencer_if.sv
// pwm_sequencer_if: byte-wide register access channel between the bus front
// end (master) and pwm_sequencer (slave).
//   req_valid_i/req_ready_o : request handshake, accepted when both high
//   req_write_i             : 1 = write, 0 = read
//   req_addr_i/req_wdata_i  : register address and write data
//   rsp_valid_o/rsp_rdata_o : one-cycle read response pulse and data
interface pwm_sequencer_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_write_i;
  logic [7:0] req_addr_i;
  logic [7:0] req_wdata_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/pwm_sequencer_timebase.sv
// pwm_timebase: prescaler and 12-bit PWM counter with sleep hold.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   i_sleep_we      : MODE1 write strobe (accept edge)
//   i_sleep_wdata   : MODE1.SLEEP value being written
//   i_prescale      : PRE_SCALE; prescaler counts 0..i_prescale
//   o_sleep         : current SLEEP state (holds MODE1.SLEEP)
//   o_counter       : PWM timebase
//   o_wrap          : high in the cycle whose closing edge takes counter 4095->0
module pwm_timebase
  import pwm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_sleep_we,
  input  logic        i_sleep_wdata,
  input  logic [7:0]  i_prescale,
  output logic        o_sleep,
  output logic [11:0] o_counter,
  output logic        o_wrap
);

  tb_state_e   r_state, w_state_next;
  logic [7:0]  r_presc, w_presc_next;
  logic [11:0] r_count, w_count_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= TB_SLEEP;
      r_presc <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_count <= w_count_next;
    end
  end

  // The state register is the MODE1.SLEEP bit itself, so a SLEEP write acts
  // from the next cycle and a wake starts counting from prescaler 0 at once.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_count_next = r_count;
    o_wrap       = 1'b0;
    if (i_sleep_we) begin
      w_state_next = i_sleep_wdata ? TB_SLEEP : TB_RUN;
    end
    case (r_state)
      TB_RUN: begin
        if (r_presc == i_prescale) begin
          w_presc_next = '0;
          w_count_next = r_count + 12'd1;
          o_wrap       = (r_count == '1);
        end else begin
          w_presc_next = r_presc + 8'd1;
        end
      end
      default: begin
        w_presc_next = '0;
        w_count_next = '0;
      end
    endcase
  end

  assign o_sleep   = (r_state == TB_SLEEP);
  assign o_counter = r_count;

endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: register bank and timebase controller for pwm_driver.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   bus           : register access channel (slave side)
//   counter_o     : 12-bit PWM timebase
//   high_o/low_o  : active ON/OFF counts, channel n at [12n+11:12n]
//   on_o/off_o    : active full-on / full-off flags
//   sleep_o       : MODE1.SLEEP
// LED writes go to staging registers; staging is copied to the active set at
// the counter wrap, or every cycle while asleep.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter logic [7:0] PRESCALE_MIN = 8'd3,
  parameter logic [7:0] PRESCALE_RST = 8'h1E
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  pwm_sequencer_if.slave          bus,
  output logic [11:0]             counter_o,
  output logic [NUM_CH*12-1:0]    high_o,
  output logic [NUM_CH*12-1:0]    low_o,
  output logic [NUM_CH-1:0]       on_o,
  output logic [NUM_CH-1:0]       off_o,
  output logic                    sleep_o
);

  logic       r_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic [6:0] r_mode1;      // MODE1 bits {7:5,3:0}; SLEEP lives in the timebase
  logic [7:0] r_prescale;
  led_regs_t  r_stage  [NUM_CH];
  led_regs_t  r_active [NUM_CH];

  logic       w_accept, w_wr, w_rd;
  logic       w_is_mode1, w_is_presc, w_is_led, w_is_all;
  logic [7:0] w_led_off, w_all_off;
  logic [3:0] w_ch;
  logic [1:0] w_sel, w_all_sel;
  logic [7:0] w_rd_data;
  logic       w_sleep, w_wrap;

  assign w_accept = bus.req_valid_i && r_ready;
  assign w_wr     = w_accept && bus.req_write_i;
  assign w_rd     = w_accept && !bus.req_write_i;

  assign w_led_off  = bus.req_addr_i - ADDR_LED0_ON_L;
  assign w_all_off  = bus.req_addr_i - ADDR_ALL_LED_ON_L;
  assign w_is_mode1 = (bus.req_addr_i == ADDR_MODE1);
  assign w_is_presc = (bus.req_addr_i == ADDR_PRE_SCALE);
  assign w_is_led   = (bus.req_addr_i >= ADDR_LED0_ON_L) && (w_led_off[7:6] == 2'b00);
  assign w_is_all   = (w_all_off[7:2] == 6'd0);
  assign w_ch       = w_led_off[5:2];
  assign w_sel      = w_led_off[1:0];
  assign w_all_sel  = w_all_off[1:0];

  always_comb begin
    w_rd_data = '0;
    if (w_is_mode1) begin
      w_rd_data = {r_mode1[6:4], w_sleep, r_mode1[3:0]};
    end else if (w_is_presc) begin
      w_rd_data = r_prescale;
    end else if (w_is_led) begin
      w_rd_data = led_rd_byte(r_stage[w_ch], w_sel);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mode1     <= '0;
      r_prescale  <= PRESCALE_RST;
    end else begin
      r_ready     <= 1'b1;
      r_rsp_valid <= w_rd;
      if (w_rd) begin
        r_rsp_rdata <= w_rd_data;
      end
      if (w_wr && w_is_mode1) begin
        r_mode1 <= {bus.req_wdata_i[7:5], bus.req_wdata_i[3:0]};
      end
      if (w_wr && w_is_presc && w_sleep) begin
        r_prescale <= (bus.req_wdata_i < PRESCALE_MIN) ? PRESCALE_MIN : bus.req_wdata_i;
      end
    end
  end

  // Commit samples staging before this edge's write, so a write accepted on
  // the wrap edge waits for the following wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        r_stage[n]  <= LED_RST;
        r_active[n] <= LED_RST;
      end
    end else begin
      if (w_sleep || w_wrap) begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
          r_active[n] <= r_stage[n];
        end
      end
      if (w_wr && w_is_led) begin
        r_stage[w_ch] <= led_wr_byte(r_stage[w_ch], w_sel, bus.req_wdata_i);
      end else if (w_wr && w_is_all) begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
          r_stage[n] <= led_wr_byte(r_stage[n], w_all_sel, bus.req_wdata_i);
        end
      end
    end
  end

  pwm_timebase u_timebase (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .i_sleep_we    (w_wr && w_is_mode1),
    .i_sleep_wdata (bus.req_wdata_i[SLEEP_BIT]),
    .i_prescale    (r_prescale),
    .o_sleep       (w_sleep),
    .o_counter     (counter_o),
    .o_wrap        (w_wrap)
  );

  always_comb begin
    high_o = '0;
    low_o  = '0;
    on_o   = '0;
    off_o  = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      high_o[12*n +: 12] = r_active[n].on;
      low_o[12*n +: 12]  = r_active[n].off;
      on_o[n]            = r_active[n].full_on;
      off_o[n]           = r_active[n].full_off;
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign sleep_o         = w_sleep;

endmodule

// File: tb/tb_pwm_sequencer.sv
module tb_pwm_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  counter;
  logic [191:0] high, low;
  logic [15:0]  on_f, off_f;
  logic         sleep;

  pwm_sequencer_if bus ();

  pwm_sequencer #(.PRESCALE_MIN(8'd3), .PRESCALE_RST(8'h1E)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .counter_o (counter),
    .high_o    (high),
    .low_o     (low),
    .on_o      (on_f),
    .off_o     (off_f),
    .sleep_o   (sleep)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_exp;

  // Scoreboard: every read response is compared to the value queued at issue.
  always @(negedge clk) begin
    if (bus.rsp_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got %02h with no read outstanding", bus.rsp_rdata_o);
      end else begin
        m_exp = exp_q.pop_front();
        if (bus.rsp_rdata_o !== m_exp) begin
          errors++;
          $display("FAIL rsp_data: got %02h expected %02h", bus.rsp_rdata_o, m_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] fld(input logic [191:0] v, input int n);
    return v[12*n +: 12];
  endfunction

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] e);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL read_latency: rsp_valid %b expected 1 one cycle after accept (addr %02h)",
               bus.rsp_valid_o, a);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_missing: %0d responses outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_counter(input logic [11:0] v, input int limit);
    int n = 0;
    @(negedge clk);
    while (counter !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (counter !== v) begin
      errors++;
      $display("FAIL counter_wait: got %0d expected %0d within %0d cycles", counter, v, limit);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("rst_sleep", sleep, 1);
    chk("rst_counter", counter, 0);
    chk("rst_off", off_f, 16'hFFFF);
    chk("rst_on", on_f, 0);
    chk("rst_high", high, 0);
    chk("rst_low", low, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.req_ready_o, 1);
    bus_read(8'h00, 8'h10);
    bus_read(8'hFE, 8'h1E);
    bus_read(8'h09, 8'h10);
    bus_read(8'h06, 8'h00);
    bus_read(8'h50, 8'h00);
    bus_read(8'hFA, 8'h00);
    drain();
  endtask

  task automatic test_sleep_write();
    bus_write(8'hFD, 8'h00);              // ALL_LED_OFF_H: clear full-off
    @(negedge clk);
    chk("sleep_commit_not_yet", off_f, 16'hFFFF);
    @(negedge clk);
    chk("sleep_commit_1cyc", off_f, 16'h0000);
    bus_write(8'h0A, 8'h23);              // LED1 ON_L
    bus_write(8'h0B, 8'h01);              // LED1 ON_H
    bus_write(8'h13, 8'hF5);              // LED3 ON_H, full-on, upper bits discarded
    @(negedge clk);
    @(negedge clk);
    chk("sleep_led1_high", fld(high, 1), 12'h123);
    chk("sleep_led3_high", fld(high, 3), 12'h500);
    chk("sleep_on_flags", on_f, 16'h0008);
    bus_read(8'h13, 8'h15);
    drain();
  endtask

  task automatic test_prescale();
    bus_write(8'hFE, 8'h01);
    bus_read(8'hFE, 8'h03);
    drain();
    bus_write(8'h00, 8'h00);              // wake
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk("wake_counter", counter, 12'(k / 4));
    end
    chk("wake_sleep", sleep, 0);
    bus_write(8'hFE, 8'h02);              // ignored while running
    bus_read(8'hFE, 8'h03);
    drain();
  endtask

  task automatic test_commit_wrap();
    bus_write(8'hFD, 8'h10);              // ALL_LED_OFF_H full-off
    bus_write(8'h0A, 8'h00);
    bus_write(8'h0B, 8'h00);
    bus_write(8'h0C, 8'h00);
    bus_write(8'h0D, 8'h08);              // LED1 OFF = 0x800, full-off clear
    bus_read(8'h1D, 8'h10);               // LED5 OFF_H
    bus_read(8'h0D, 8'h08);
    drain();
    chk("pre_wrap_led1_high", fld(high, 1), 12'h123);
    chk("pre_wrap_led1_low", fld(low, 1), 12'h000);
    chk("pre_wrap_off", off_f, 16'h0000);
    wait_counter(12'd4095, 20000);
    chk("last_cycle_led1_high", fld(high, 1), 12'h123);
    repeat (3) @(posedge clk);
    bus_write(8'h0E, 8'h55);              // LED2 ON_L accepted on the wrap edge
    @(negedge clk);
    chk("wrap_counter", counter, 0);
    chk("wrap_led1_high", fld(high, 1), 12'h000);
    chk("wrap_led1_low", fld(low, 1), 12'h800);
    chk("wrap_off", off_f, 16'hFFFD);
    chk("wrap_on_both_flags", on_f, 16'h0008);
    chk("wrap_led3_high", fld(high, 3), 12'h500);
    chk("wrap_led2_missed", fld(high, 2), 12'h000);
    bus_read(8'h0E, 8'h55);
    drain();
    wait_counter(12'd4095, 20000);
    chk("led2_still_pending", fld(high, 2), 12'h000);
    wait_counter(12'd0, 10);
    chk("led2_next_wrap", fld(high, 2), 12'h055);
  endtask

  task automatic test_back_to_back();
    bit         w [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] a [10] = '{8'h24, 8'h24, 8'h00, 8'h00, 8'hFE, 8'h45, 8'h46, 8'h05, 8'hFB, 8'h80};
    logic [7:0] d [10] = '{8'hA5, 8'hA5, 8'h21, 8'h21, 8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_write_i = w[i];
      bus.req_addr_i  = a[i];
      bus.req_wdata_i = d[i];
      if (!w[i]) exp_q.push_back(d[i]);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    drain();
    chk("b2b_still_running", sleep, 0);
  endtask

  task automatic test_sleep_entry();
    int n = 0;
    while (counter < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_sleep_counter_running", (counter >= 5), 1);
    bus_write(8'h00, 8'h10);
    @(negedge clk);
    chk("sleep_entry_flag", sleep, 1);
    @(negedge clk);
    chk("sleep_entry_counter", counter, 0);
    chk("sleep_entry_commit_led7", fld(low, 7), 12'h0A5);
    bus_read(8'h00, 8'h10);
    drain();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bus_write(8'h00, 8'h00);
    while (counter < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus_write(8'h16, 8'h77);              // LED4 ON_L, pending commit
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_counter", counter, 0);
    chk("midrst_sleep", sleep, 1);
    chk("midrst_ready", bus.req_ready_o, 0);
    chk("midrst_rdata", bus.rsp_rdata_o, 0);
    chk("midrst_off", off_f, 16'hFFFF);
    chk("midrst_on", on_f, 0);
    chk("midrst_high", high, 0);
    chk("midrst_low", low, 0);
    rst_n = 1'b1;
    bus_read(8'h16, 8'h00);
    bus_read(8'h09, 8'h10);
    bus_read(8'hFE, 8'h1E);
    bus_read(8'h00, 8'h10);
    drain();
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    test_reset();
    test_sleep_write();
    test_prescale();
    test_commit_wrap();
    test_back_to_back();
    test_sleep_entry();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
